// File: rtl/snap_ring_capture.sv
// snap_ring_capture
//   Snapshot capture engine that streams qualified samples into a single
//   BRAM write port. Supports a one-shot mode (fill the whole buffer starting
//   at the trigger) and a circular mode (keep overwriting pre-trigger history,
//   then write post_len more samples counting the trigger sample).
//
// Ports
//   i_clk          fabric clock, rising edge
//   i_rst          synchronous active-high reset
//   i_din          sample data
//   i_din_valid    sample qualifier
//   i_arm          level input; a rising edge starts a new capture
//   i_trig         trigger, only looked at on valid samples while waiting
//   i_use_trig     1 = wait for i_trig, 0 = trigger on the first valid sample
//   i_circ         1 = circular pre-trigger mode, 0 = one-shot mode
//   i_post_len     post-trigger sample count for circular mode (0 acts as 1)
//   o_bram_we      BRAM port-A write enable
//   o_bram_addr    BRAM port-A word address
//   o_bram_wr_data BRAM port-A write data
//   o_done         capture complete, held until the next arm edge
//   o_last_addr    address of the final written word, valid while o_done=1
//   o_wrapped      write pointer wrapped at least once in this capture
//
// State      | meaning
// -----------+-----------------------------------------------------------
// S_IDLE     | after reset, nothing armed
// S_WAIT_TRIG| armed; circular mode records history, one-shot writes nothing
// S_POST     | triggered; writing post-trigger samples
// S_DONE     | capture finished, outputs frozen until the next arm edge

module snap_ring_capture #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 12,
  parameter int POST_WIDTH = ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [DATA_WIDTH-1:0] i_din,
  input  logic                  i_din_valid,
  input  logic                  i_arm,
  input  logic                  i_trig,
  input  logic                  i_use_trig,
  input  logic                  i_circ,
  input  logic [POST_WIDTH-1:0] i_post_len,
  output logic                  o_bram_we,
  output logic [ADDR_WIDTH-1:0] o_bram_addr,
  output logic [DATA_WIDTH-1:0] o_bram_wr_data,
  output logic                  o_done,
  output logic [ADDR_WIDTH-1:0] o_last_addr,
  output logic                  o_wrapped
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_WAIT_TRIG = 2'd1,
    S_POST      = 2'd2,
    S_DONE      = 2'd3
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic                  r_arm_d;
  logic                  r_arm_blk;
  logic                  r_use_trig;
  logic                  r_circ;
  logic [POST_WIDTH-1:0] r_post_len;
  logic [POST_WIDTH:0]   r_post_cnt;
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic                  r_last_wr;

  logic                  r_bram_we;
  logic [ADDR_WIDTH-1:0] r_bram_addr;
  logic [DATA_WIDTH-1:0] r_bram_wr_data;
  logic                  r_done;
  logic [ADDR_WIDTH-1:0] r_last_addr;
  logic                  r_wrapped;

  logic                  w_arm_edge;
  logic                  w_trig_hit;
  logic                  w_wr;
  logic                  w_post_phase;
  logic                  w_final;
  logic                  w_ptr_max;
  logic [POST_WIDTH:0]   w_post_eff;
  logic [POST_WIDTH:0]   w_post_cnt_nxt;

  // r_arm_blk suppresses an edge when arm is already high as reset releases;
  // arm must be seen low once before a rising edge counts.
  assign w_arm_edge     = i_arm & ~r_arm_d & ~r_arm_blk;
  assign w_ptr_max      = (r_wr_ptr == '1);
  assign w_post_eff     = (r_post_len == '0) ? (POST_WIDTH+1)'(1) : {1'b0, r_post_len};
  assign w_post_cnt_nxt = r_post_cnt + (POST_WIDTH+1)'(1);

  // State register
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_WAIT_TRIG: begin
        if (w_post_phase) begin
          w_state_nxt = w_final ? S_DONE : S_POST;
        end
      end
      S_POST: begin
        if (w_final) begin
          w_state_nxt = S_DONE;
        end
      end
      default: w_state_nxt = r_state;
    endcase
    if (w_arm_edge) begin
      w_state_nxt = (i_use_trig | i_circ) ? S_WAIT_TRIG : S_POST;
    end
  end

  // Output / write-qualification logic. The sample on an arm-edge cycle is
  // never written; the capture starts with the next valid sample.
  always_comb begin
    w_trig_hit   = i_din_valid & (i_trig | ~r_use_trig);
    w_wr         = 1'b0;
    w_post_phase = 1'b0;
    w_final      = 1'b0;
    if (!w_arm_edge && i_din_valid) begin
      case (r_state)
        S_WAIT_TRIG: begin
          w_post_phase = w_trig_hit;
          w_wr         = r_circ | w_trig_hit;
        end
        S_POST: begin
          w_post_phase = 1'b1;
          w_wr         = 1'b1;
        end
        default: begin
          w_post_phase = 1'b0;
          w_wr         = 1'b0;
        end
      endcase
    end
    // One-shot ends when the pointer is about to wrap (full buffer written).
    if (w_wr && w_post_phase) begin
      w_final = r_circ ? (w_post_cnt_nxt == w_post_eff) : w_ptr_max;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_arm_d        <= 1'b0;
      r_arm_blk      <= 1'b1;
      r_use_trig     <= 1'b0;
      r_circ         <= 1'b0;
      r_post_len     <= '0;
      r_post_cnt     <= '0;
      r_wr_ptr       <= '0;
      r_last_wr      <= 1'b0;
      r_bram_we      <= 1'b0;
      r_bram_addr    <= '0;
      r_bram_wr_data <= '0;
      r_done         <= 1'b0;
      r_last_addr    <= '0;
      r_wrapped      <= 1'b0;
    end else begin
      r_arm_d   <= i_arm;
      if (!i_arm) begin
        r_arm_blk <= 1'b0;
      end
      r_bram_we <= w_wr;
      r_last_wr <= w_final;
      if (w_wr) begin
        r_bram_addr    <= r_wr_ptr;
        r_bram_wr_data <= i_din;
        r_wr_ptr       <= r_wr_ptr + ADDR_WIDTH'(1);
        if (r_circ && w_ptr_max) begin
          r_wrapped <= 1'b1;
        end
      end
      if (w_wr && w_post_phase) begin
        r_post_cnt <= w_post_cnt_nxt;
      end
      // done rises the cycle after the final write pulse is on the port
      if (r_last_wr) begin
        r_done      <= 1'b1;
        r_last_addr <= r_bram_addr;
      end
      if (w_arm_edge) begin
        r_wr_ptr   <= '0;
        r_done     <= 1'b0;
        r_wrapped  <= 1'b0;
        r_post_cnt <= '0;
        r_last_wr  <= 1'b0;
        r_use_trig <= i_use_trig;
        r_circ     <= i_circ;
        r_post_len <= i_post_len;
      end
    end
  end

  assign o_bram_we      = r_bram_we;
  assign o_bram_addr    = r_bram_addr;
  assign o_bram_wr_data = r_bram_wr_data;
  assign o_done         = r_done;
  assign o_last_addr    = r_last_addr;
  assign o_wrapped      = r_wrapped;

endmodule

// File: tb/tb_snap_ring_capture.sv
module tb_snap_ring_capture;

  localparam int DW    = 16;
  localparam int AW    = 4;
  localparam int PW    = 6;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [DW-1:0] din = '0;
  logic          din_valid = 1'b0;
  logic          arm = 1'b0;
  logic          trig = 1'b0;
  logic          use_trig = 1'b0;
  logic          circ = 1'b0;
  logic [PW-1:0] post_len = '0;
  logic          bram_we;
  logic [AW-1:0] bram_addr;
  logic [DW-1:0] bram_wr_data;
  logic          done;
  logic [AW-1:0] last_addr;
  logic          wrapped;

  snap_ring_capture #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .POST_WIDTH(PW)) dut (
    .i_clk(clk), .i_rst(rst), .i_din(din), .i_din_valid(din_valid),
    .i_arm(arm), .i_trig(trig), .i_use_trig(use_trig), .i_circ(circ),
    .i_post_len(post_len), .o_bram_we(bram_we), .o_bram_addr(bram_addr),
    .o_bram_wr_data(bram_wr_data), .o_done(done), .o_last_addr(last_addr),
    .o_wrapped(wrapped)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model (sample-count based) ----------------
  // phase: 0 idle, 1 waiting for trigger, 2 post-trigger, 3 finished
  int     m_phase = 0;
  int     m_written = 0;
  int     m_post = 0;
  int     m_plen = 1;
  bit     m_circ = 0, m_ut = 0;
  bit     m_arm_prev = 0, m_blk = 1, m_pend = 0, m_edge = 0, m_hit = 0, m_posting = 0;
  bit     exp_we = 0, exp_done = 0, exp_wr = 0;
  int     exp_addr = 0, exp_last = 0;
  logic [DW-1:0] exp_data = '0;

  always @(posedge clk) begin
    if (rst) begin
      m_phase = 0; m_written = 0; m_post = 0; m_pend = 0;
      m_arm_prev = 0; m_blk = 1;
      exp_we = 0; exp_done = 0; exp_wr = 0; exp_addr = 0; exp_last = 0; exp_data = '0;
    end else begin
      m_edge = arm && !m_arm_prev && !m_blk;
      if (!arm) m_blk = 0;
      m_arm_prev = arm;
      if (m_pend) begin
        exp_done = 1;
        exp_last = (m_written - 1) % DEPTH;
        m_pend   = 0;
      end
      exp_we = 0;
      if (m_edge) begin
        m_written = 0; m_post = 0; exp_done = 0; exp_wr = 0; m_pend = 0;
        m_circ = circ; m_ut = use_trig;
        m_plen = (post_len == 0) ? 1 : int'(post_len);
        m_phase = (use_trig || circ) ? 1 : 2;
      end else if (din_valid) begin
        m_hit     = trig || !m_ut;
        m_posting = (m_phase == 2) || (m_phase == 1 && m_hit);
        if (m_phase == 2 || (m_phase == 1 && (m_circ || m_hit))) begin
          exp_we   = 1;
          exp_addr = m_written % DEPTH;
          exp_data = din;
          m_written++;
          if (m_circ && m_written >= DEPTH) exp_wr = 1;
          if (m_posting) begin
            m_post++;
            if (m_circ ? (m_post == m_plen) : (m_written == DEPTH)) begin
              m_phase = 3;
              m_pend  = 1;
            end else begin
              m_phase = 2;
            end
          end
        end
      end
    end
  end

  // Compare process: every negedge after the first reset edge
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      chk("bram_we", bram_we, exp_we);
      if (exp_we) begin
        chk("bram_addr", bram_addr, exp_addr);
        chk("bram_wr_data", bram_wr_data, exp_data);
      end
      chk("done", done, exp_done);
      chk("wrapped", wrapped, exp_wr);
      if (exp_done) chk("last_addr", last_addr, exp_last);
    end
  end

  // Write monitor for the literal end-of-test checks
  int            wr_cnt = 0;
  int            bad_wr = 0;
  logic [AW-1:0] first_addr = '0;
  logic [DW-1:0] first_data = '0;
  always @(negedge clk) begin
    if (bram_we === 1'b1) begin
      wr_cnt++;
      if (wr_cnt == 1) begin
        first_addr = bram_addr;
        first_data = bram_wr_data;
      end
      if (bram_wr_data === 16'hBEEF) bad_wr++;
    end
  end

  task automatic step(input bit a, input bit v, input logic [DW-1:0] d, input bit t);
    @(negedge clk);
    arm = a; din_valid = v; din = d; trig = t;
  endtask

  task automatic wait_done(input int budget);
    int k;
    k = 0;
    while (done !== 1'b1 && k < budget) begin
      @(negedge clk);
      k++;
    end
    if (done !== 1'b1) chk("done_timeout", 32'(done), 1);
  endtask

  task automatic setup(input bit ut, input bit c, input logic [PW-1:0] pl);
    step(0, 0, '0, 0);
    use_trig = ut; circ = c; post_len = pl;
    step(0, 0, '0, 0);
    wr_cnt = 0;
    step(1, 0, '0, 0);
  endtask

  initial begin
    int vcnt;
    // reset state
    repeat (3) @(negedge clk);
    chk("rst_we", bram_we, 0);
    chk("rst_addr", bram_addr, 0);
    chk("rst_data", bram_wr_data, 0);
    chk("rst_done", done, 0);
    chk("rst_last", last_addr, 0);
    chk("rst_wrapped", wrapped, 0);
    rst = 1'b0;

    // one-shot, immediate trigger, 16 contiguous samples
    setup(0, 0, 0);
    for (int i = 0; i < 16; i++) begin
      step(1, 1, DW'(i), 0);
      if (i == 5) circ = 1;            // mid-capture change must be ignored
    end
    step(1, 0, '0, 0);
    wait_done(6);
    chk("os_last_addr", last_addr, 15);
    chk("os_wrapped", wrapped, 0);
    chk("os_first_addr", first_addr, 0);
    for (int i = 0; i < 3; i++) step(1, 1, DW'(50 + i), 1);
    step(1, 0, '0, 0);
    chk("os_wr_cnt", wr_cnt, 16);

    // circular, post_len=4, trigger on sample 20
    setup(1, 1, 4);
    for (int i = 0; i < 26; i++) step(1, 1, DW'(i), (i == 20 || i == 22));
    step(1, 0, '0, 0);
    wait_done(6);
    chk("circ_last_addr", last_addr, 7);
    chk("circ_wrapped", wrapped, 1);
    chk("circ_wr_cnt", wr_cnt, 24);

    // re-arm while done clears done/wrapped; one-shot with trigger, 50% valid
    step(0, 0, '0, 0);
    use_trig = 1; circ = 0; post_len = 0;
    step(0, 0, '0, 0);
    wr_cnt = 0;
    step(1, 0, '0, 0);
    step(1, 0, '0, 0);
    chk("rearm_done", done, 0);
    chk("rearm_wrapped", wrapped, 0);
    vcnt = 0;
    for (int i = 0; i < 46; i++) begin
      if (i % 2 == 1) begin
        step(1, 1, DW'(100 + vcnt), (vcnt == 4));
        vcnt++;
      end else begin
        step(1, 0, 16'hBEEF, 1);
      end
    end
    step(1, 0, '0, 0);
    wait_done(6);
    chk("tog_wr_cnt", wr_cnt, 16);
    chk("tog_first_addr", first_addr, 0);
    chk("tog_first_data", first_data, 104);
    chk("tog_last_addr", last_addr, 15);
    chk("tog_bad_wr", bad_wr, 0);

    // reset mid-capture after 6 writes
    setup(0, 0, 0);
    for (int i = 0; i < 6; i++) step(1, 1, DW'(200 + i), 0);
    @(negedge clk);
    rst = 1'b1; din = DW'(206);
    @(negedge clk);
    chk("abort_we", bram_we, 0);
    chk("abort_addr", bram_addr, 0);
    chk("abort_data", bram_wr_data, 0);
    chk("abort_done", done, 0);
    chk("abort_wrapped", wrapped, 0);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) step(1, 1, DW'(210 + i), 0);
    step(1, 0, '0, 0);
    chk("abort_wr_cnt", wr_cnt, 6);
    step(0, 0, '0, 0);
    wr_cnt = 0;
    step(1, 0, '0, 0);
    step(1, 1, DW'(220), 0);
    step(1, 1, DW'(221), 0);
    step(1, 0, '0, 0);
    chk("restart_addr", first_addr, 0);
    chk("restart_data", first_data, 220);

    // circular, post_len=0, arm edge coincident with a triggering sample
    step(0, 0, '0, 0);
    use_trig = 1; circ = 1; post_len = 0;
    step(0, 0, '0, 0);
    wr_cnt = 0;
    step(1, 1, DW'(300), 1);
    step(1, 1, DW'(301), 1);
    step(1, 1, DW'(302), 1);
    step(1, 0, '0, 0);
    wait_done(6);
    chk("pl0_wr_cnt", wr_cnt, 1);
    chk("pl0_first_addr", first_addr, 0);
    chk("pl0_first_data", first_data, 301);
    chk("pl0_last_addr", last_addr, 0);

    // circular, post_len longer than buffer
    setup(1, 1, 20);
    for (int i = 0; i < 28; i++) step(1, 1, DW'(400 + i), (i == 3));
    step(1, 0, '0, 0);
    wait_done(6);
    chk("long_wr_cnt", wr_cnt, 23);
    chk("long_last_addr", last_addr, 6);
    chk("long_wrapped", wrapped, 1);

    // circular without trigger wait: first valid is the trigger
    setup(0, 1, 3);
    for (int i = 0; i < 6; i++) step(1, (i != 1), DW'(500 + i), 0);
    step(1, 0, '0, 0);
    wait_done(6);
    chk("imm_wr_cnt", wr_cnt, 3);
    chk("imm_last_addr", last_addr, 2);

    step(0, 0, '0, 0);
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/snap_ring_capture.md
SNAP_RING_CAPTURE -- requirements
Module: snap_ring_capture

Interface
REQ-001 Parameter DATA_WIDTH, default 128, sample and BRAM data width in bits.
REQ-002 Parameter ADDR_WIDTH, default 12, BRAM word-address width; buffer depth = 2^ADDR_WIDTH words.
REQ-003 Parameter POST_WIDTH, default ADDR_WIDTH, width of the post-trigger count input.
REQ-004 clk  in  1  single fabric clock; all logic on rising edge.
REQ-005 rst  in  1  synchronous, active-high reset.
REQ-006 din  in  DATA_WIDTH  sample data.
REQ-007 din_valid  in  1  din qualifier.
REQ-008 arm  in  1  level; rising edge starts a capture.
REQ-009 trig  in  1  trigger, sampled only while qualified by din_valid.
REQ-010 use_trig  in  1  1 = wait for trig; 0 = trigger immediately on arm.
REQ-011 circ  in  1  1 = circular pre-trigger mode; 0 = one-shot mode.
REQ-012 post_len  in  POST_WIDTH  samples written after trigger in circular mode.
REQ-013 bram_we  out  1  BRAM port-A write enable.
REQ-014 bram_addr  out  ADDR_WIDTH  BRAM port-A word address.
REQ-015 bram_wr_data  out  DATA_WIDTH  BRAM port-A write data.
REQ-016 done  out  1  capture complete, held until next arm edge or rst.
REQ-017 last_addr  out  ADDR_WIDTH  address of final written word, valid when done=1.
REQ-018 wrapped  out  1  buffer wrapped at least once during this capture.

Function
REQ-019 States IDLE, WAIT_TRIG, POST, DONE; arm rising edge = arm high and registered arm low previous cycle.
REQ-020 Arm edge in any state: address counter <- 0, done <- 0, wrapped <- 0, post counter <- 0; next state WAIT_TRIG if use_trig=1 or circ=1, else POST.
REQ-021 Inputs use_trig, circ, post_len latched on the arm edge; changes mid-capture ignored.
REQ-022 Write path: state WAIT_TRIG (circ=1 only) or POST, and din_valid=1 -> next cycle bram_we=1, bram_wr_data=din, bram_addr=current counter; counter then increments mod 2^ADDR_WIDTH. Latency din->BRAM one cycle.
REQ-023 WAIT_TRIG with circ=0: no writes; counter held at 0.
REQ-024 Counter wrap from 2^ADDR_WIDTH-1 to 0 sets wrapped=1 (sticky until next arm edge or rst).
REQ-025 WAIT_TRIG: din_valid=1 and trig=1 -> that sample is written (circ=1) or is the first written sample (circ=0); transition to POST; post counter counts this sample as 1.
REQ-026 POST, circ=0: stop after 2^ADDR_WIDTH samples written (counter wraps to 0) -> DONE; wrapped stays 0.
REQ-027 POST, circ=1: stop after post_len samples including trigger sample -> DONE; post_len=0 treated as 1.
REQ-028 post_len >= 2^ADDR_WIDTH allowed; capture overwrites pre-trigger data, wrapped=1.
REQ-029 Entering DONE: last_addr <- address of final written word, done=1 on the cycle after the final bram_we pulse.
REQ-030 DONE: no writes; remain until arm edge.
REQ-031 arm falling or held high: no effect; trig outside WAIT_TRIG ignored.
REQ-032 Arm edge coincident with din_valid: sample not written; capture starts on next valid.

Reset
REQ-033 rst=1: state IDLE, bram_we=0, bram_addr=0, bram_wr_data=0, done=0, last_addr=0, wrapped=0, arm register=0.
REQ-034 rst asserted mid-capture aborts immediately; no further bram_we; arm high at rst release not an edge until it falls and rises again.

Verification
REQ-035 ADDR_WIDTH=4, circ=0, use_trig=0, arm edge, din_valid continuous din=0..15 -> 16 writes at addr 0..15, done=1 one cycle after last, last_addr=15, wrapped=0.
REQ-036 circ=1, post_len=4, 20 valid samples then trig on sample value 20 -> writes continue, trig sample + 3 more, done=1, last_addr=(23 mod 16)=7, wrapped=1.
REQ-037 circ=0, use_trig=1, din_valid toggling 50%, trig on 5th valid -> no writes before trigger, first write addr 0 = trig sample, 16 writes total, no write on invalid cycles.
REQ-038 rst pulsed after 6 writes in POST -> bram_we=0 next cycle, all outputs 0, no writes until new arm edge.
REQ-039 New arm edge while done=1 -> done=0, wrapped=0, capture restarts at addr 0.
REQ-040 circ=1, post_len=0, trig on first valid -> exactly one write at addr 0, last_addr=0, done=1.
